ram_read_streamer: RTL and testbench
====================================

RAM_READ_STREAMER -- requirements
Module: ram_read_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width of the RAM and the output stream.
REQ-002 Parameter ADDR_WIDTH, default 10, RAM address width.
REQ-003 clock  input  1  single clock for all logic; the RAM read port shares this clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a pass; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_WIDTH  first RAM address of the pass; latched on accepted start.
REQ-007 length  input  ADDR_WIDTH+1  words per pass, range 0..2^ADDR_WIDTH; latched on accepted start.
REQ-008 stop  input  1  ends looping; used only when RAM_READ_STREAMER_LOOP_EN is defined.
REQ-009 read_addr  output  ADDR_WIDTH  address to the RAM read port; RAM returns q one cycle later.
REQ-010 q  input  DATA_WIDTH  registered RAM read data.
REQ-011 out_data  output  DATA_WIDTH  stream data.
REQ-012 out_valid  output  1  stream data valid.
REQ-013 out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-014 out_last  output  1  marks the final word of a pass; qualified by out_valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at the end of the operation.

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE, and DRAIN.
REQ-018 IDLE->ISSUE SHALL occur on start with length>0; start with length==0 SHALL pulse done on the next cycle, emit no data, and remain in IDLE.
REQ-019 In ISSUE, one read SHALL be issued per cycle when credit allows; credit = FIFO occupancy + in-flight reads < 2.
REQ-020 A read issued in cycle N SHALL write q into a 2-entry output FIFO in cycle N+1; the FIFO SHALL never overflow.
REQ-021 read_addr SHALL equal (start_addr + issued_count) mod 2^ADDR_WIDTH; addresses SHALL wrap past 2^ADDR_WIDTH-1 to 0.
REQ-022 ISSUE->DRAIN SHALL occur when issued_count reaches length.
REQ-023 DRAIN->IDLE SHALL occur on the transfer of the last word, with done pulsed in the following cycle.
REQ-024 out_valid SHALL be high whenever the FIFO is non-empty; out_data and out_last SHALL hold stable while out_valid is high and out_ready is low.
REQ-025 Output order SHALL equal address issue order; no word SHALL be dropped or duplicated.
REQ-026 With out_ready held high, the first word SHALL appear 2 cycles after the start edge, and the stream SHALL then sustain 1 word per cycle.
REQ-027 out_ready SHALL have no combinational path to read_addr.
REQ-028 start SHALL be ignored while busy is high.

Reset
REQ-029 Reset SHALL force IDLE, flush the FIFO, cancel in-flight reads, and clear all counters, at any time including mid-pass.
REQ-030 Reset values SHALL be: read_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.

Configuration
REQ-031 Macro RAM_READ_STREAMER_LOOP_EN: when defined, a pass that ends without stop SHALL restart at start_addr with no gap cycle. out_last SHALL mark the end of each pass. stop, sampled any time during busy, SHALL end operation after the current pass completes, with done pulsed once.
REQ-032 Without RAM_READ_STREAMER_LOOP_EN, exactly one pass SHALL run per start, and stop SHALL be ignored.

Verification
REQ-033 Scenario: start_addr=0x3FE, length=4, out_ready=1 -> read_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; 4 words in order; out_last on the 4th; done 1 cycle later.
REQ-034 Scenario: length=8, out_ready toggled 1,0,0,1 repeating -> all 8 words in order, no loss; out_data stable during stalls; no read issued when credit is 0.
REQ-035 Scenario: start with length=0 -> done on the next cycle; out_valid stays 0; busy stays 0.
REQ-036 Scenario: reset asserted mid-pass after 3 of 10 words -> out_valid=0 and busy=0 immediately; a new start with length=2 streams correct data.
REQ-037 Scenario: start pulsed during busy -> ignored; the current pass completes unchanged.
REQ-038 Scenario (LOOP_EN): length=3, stop asserted during the 2nd pass -> 6 words total; out_last on words 3 and 6; a single done pulse.

Source files
------------

// File: rtl/ram_read_streamer.sv
// ram_read_streamer
//   Reads a block of words out of a synchronous RAM (one cycle read latency)
//   and presents them as a valid/ready stream. A 2-entry output FIFO absorbs
//   the RAM latency, so the stream sustains one word per cycle when the
//   consumer keeps out_ready high.
//
// Handshake: a word moves downstream on every clock edge where out_valid and
//   out_ready are both high. out_valid never depends on out_ready, and
//   out_data/out_last hold steady while out_valid is high and out_ready is low.
//
// Ports
//   clock, reset         single clock, asynchronous active-high reset
//   start                one-cycle pass request, sampled only in IDLE
//   start_addr, length   first address / word count (0..2^ADDR_WIDTH), latched on start
//   stop                 ends looping after the current pass (loop build only)
//   read_addr, q         RAM read port; q is the registered data for last cycle's address
//   out_data, out_valid, out_ready, out_last   output stream
//   busy                 high whenever not IDLE
//   done                 one-cycle pulse when the operation finishes
//   debug_state          current FSM state (IDLE=0, ISSUE=1, DRAIN=2)
//
// Build option: define RAM_READ_STREAMER_LOOP_EN to repeat the pass from
//   start_addr until stop is seen; otherwise one pass per start and stop is ignored.
module ram_read_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  stop,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            debug_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH:0]   len_reg;
  logic [ADDR_WIDTH:0]   issued_count;
  logic                  inflight;       // read issued last cycle; its q lands in the FIFO this cycle
  logic                  inflight_last;
  logic                  done_reg;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_count;

  logic                  pop;
  logic [2:0]            occupancy;
  logic                  issue;
  logic                  pass_end;
  logic                  loop_again;
  logic                  accept_start;
  logic                  zero_start;
  logic                  drain_done;

`ifdef RAM_READ_STREAMER_LOOP_EN
  logic stop_seen;

  // stop is remembered until the pass in progress finishes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stop_seen <= 1'b0;
    end else if (accept_start) begin
      stop_seen <= 1'b0;
    end else if (busy && stop) begin
      stop_seen <= 1'b1;
    end
  end

  assign loop_again = !(stop_seen || stop);
`else
  logic unused_stop;
  assign unused_stop = stop;
  assign loop_again  = 1'b0;
`endif

  assign out_valid   = (fifo_count != 2'd0);
  assign out_data    = fifo_data[rd_ptr];
  assign out_last    = fifo_last[rd_ptr];
  assign pop         = out_valid && out_ready;
  assign busy        = (state != IDLE);
  assign done        = done_reg;
  assign read_addr   = addr_reg;
  assign debug_state = state;

  // Credit counts FIFO entries plus the read in flight, less the word leaving
  // this cycle. Crediting the pop is what allows one word per cycle; out_ready
  // only reaches the address register's next value, never read_addr itself.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == ISSUE) && (occupancy < 3'd2);
  assign pass_end  = issue && (issued_count == len_reg - LEN_ONE);

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    zero_start   = 1'b0;
    drain_done   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept_start = 1'b1;
            state_next   = ISSUE;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (pass_end && !loop_again) state_next = DRAIN;
      end
      DRAIN: begin
        // Nothing is issued here, so the word leaving with an otherwise empty
        // pipeline is the final one (earlier pass-end words may sit ahead of it).
        if (pop && fifo_count == 2'd1 && !inflight) begin
          drain_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      base_addr     <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      issued_count  <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state         <= state_next;
      inflight      <= issue;
      inflight_last <= pass_end;
      done_reg      <= zero_start || drain_done;
      if (accept_start) begin
        base_addr    <= start_addr;
        addr_reg     <= start_addr;
        len_reg      <= length;
        issued_count <= '0;
      end else if (issue) begin
        if (pass_end && loop_again) begin
          addr_reg     <= base_addr;
          issued_count <= '0;
        end else begin
          addr_reg     <= addr_reg + ADDR_ONE;
          issued_count <= issued_count + LEN_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= q;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ram_read_streamer.sv
module tb_ram_read_streamer;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          stop = 1'b0;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] q = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [1:0]    debug_state;

  logic [DW-1:0] mem [1 << AW];
  logic [DW:0]   exp_q [$];   // {last, data}

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int ready_mode = 0;         // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  int phase = 0;
  logic          stall_prev = 1'b0;
  logic [DW:0]   prev_word = '0;

  ram_read_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .length(length), .stop(stop), .read_addr(read_addr), .q(q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .debug_state(debug_state)
  );

  // clock / RAM model
  always #5 clock = ~clock;
  always @(posedge clock) q <= mem[read_addr];

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // consumer
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (phase % 4 == 0) || (phase % 4 == 3);
        phase++;
      end
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // scoreboard / monitor
  always @(negedge clock) begin
    if (done) done_cnt++;
    if (!reset) begin
      if (stall_prev) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold", {15'd0, out_last, out_data}, {15'd0, prev_word});
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
        else check("stream_word", {15'd0, out_last, out_data}, {15'd0, exp_q.pop_front()});
      end
      stall_prev = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_pass(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a = addr + AW'(i);
      exp_q.push_back({(i == len - 1), mem[a]});
    end
  endtask

  // drives start for one cycle; returns just after the edge that samples it
  task automatic start_pass(input logic [AW-1:0] addr, input int len);
    @(posedge clock);
    #1;
    start      = 1'b1;
    start_addr = addr;
    length     = (AW+1)'(len);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge clock);
      c++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clock);
    check("queue_empty", exp_q.size(), 32'd0);
    check("idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d0;
    int x0;
    logic [AW-1:0] ra;
    int rl;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom_range(0, 65535));

    // reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_read_addr", {22'd0, read_addr}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, debug_state}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // address wrap, latency, throughput, last marker and done timing
    ready_mode = 0;
    push_pass(10'h3FE, 4);
    start_pass(10'h3FE, 4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 0) check("wrap_addr0", {22'd0, read_addr}, 32'h3FE);
      if (k == 1) check("wrap_addr1", {22'd0, read_addr}, 32'h3FF);
      if (k == 2) check("wrap_addr2", {22'd0, read_addr}, 32'h000);
      if (k == 3) check("wrap_addr3", {22'd0, read_addr}, 32'h001);
      check("wrap_valid", {31'd0, out_valid}, {31'd0, (k >= 2 && k <= 5)});
      check("wrap_last", {31'd0, out_last && out_valid}, {31'd0, (k == 5)});
      check("wrap_done", {31'd0, done}, {31'd0, (k == 6)});
      check("wrap_busy", {31'd0, busy}, {31'd0, (k <= 5)});
    end
    check("wrap_queue_empty", exp_q.size(), 32'd0);

    // backpressure 1,0,0,1
    ready_mode = 1;
    phase = 0;
    ra = AW'($urandom_range(0, 1023));
    push_pass(ra, 8);
    start_pass(ra, 8);
    wait_done(200);

    // zero length
    ready_mode = 0;
    d0 = done_cnt;
    start_pass(10'h123, 0);
    @(negedge clock);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_valid", {31'd0, out_valid}, 32'd0);
    check("zero_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    check("zero_done_once", {31'd0, done}, 32'd0);
    check("zero_valid2", {31'd0, out_valid}, 32'd0);
    check("zero_done_count", done_cnt - d0, 32'd1);

    // reset mid-pass
    x0 = xfer_cnt;
    push_pass(10'h040, 10);
    start_pass(10'h040, 10);
    for (int c = 0; c < 50 && xfer_cnt < x0 + 3; c++) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_state", {30'd0, debug_state}, 32'd0);
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    push_pass(10'h200, 2);
    start_pass(10'h200, 2);
    wait_done(50);

    // start while busy is ignored
    d0 = done_cnt;
    push_pass(10'h300, 6);
    start_pass(10'h300, 6);
    @(negedge clock);
    @(posedge clock);
    #1;
    start = 1'b1; start_addr = 10'h010; length = 11'd3;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(50);
    check("busy_start_done_count", done_cnt - d0, 32'd1);

    // random passes under random backpressure
    ready_mode = 2;
    for (int t = 0; t < 6; t++) begin
      ra = AW'($urandom_range(0, 1023));
      rl = $urandom_range(1, 20);
      push_pass(ra, rl);
      start_pass(ra, rl);
      wait_done(400);
    end

`ifdef RAM_READ_STREAMER_LOOP_EN
    // looping with stop during the second pass
    ready_mode = 0;
    d0 = done_cnt;
    x0 = xfer_cnt;
    push_pass(10'h3FF, 3);
    push_pass(10'h3FF, 3);
    start_pass(10'h3FF, 3);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 stop = 1'b1;
    @(posedge clock);
    #1 stop = 1'b0;
    wait_done(100);
    check("loop_words", xfer_cnt - x0, 32'd6);
    check("loop_done_count", done_cnt - d0, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
